// File: rtl/digit_scan_mux.sv
// N-digit multiplexed seven-segment scanner: four slots per digit (off, off, on, off),
// double-buffered digit data. Define DIGSCAN_LZB_EN for leading-zero blanking.
module digit_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIG_W      = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [NUM_DIGITS*DIG_W-1:0] data_in,
  input  logic                        load,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [DIG_W-1:0]            char,
  output logic                        pending,
  output logic                        frame_done
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(PRESCALE - 1);
  localparam logic [DG_W-1:0] DG_MAX = DG_W'(NUM_DIGITS - 1);
  localparam logic [1:0]      PH_ON  = 2'd2;
  localparam logic [1:0]      PH_END = 2'd3;

  logic [PC_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [DG_W-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0][DIG_W-1:0] pend_reg_q, pend_reg_d, shadow_q, shadow_d;
  logic            pend_q, pend_d;
  logic            tick, boundary, commit;
  logic [NUM_DIGITS-1:0] blank;

  assign tick       = (pre_cnt_q == PC_MAX);
  assign boundary   = tick & (phase_q == PH_END) & (dig_q == DG_MAX);
  assign frame_done = boundary;
  assign pending    = pend_q;
  // Disabling flushes pending data straight into the display buffer.
  assign commit     = pend_q & (boundary | ~enable);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    phase_d   = phase_q;
    dig_d     = dig_q;
    if (!enable) begin
      pre_cnt_d = '0;
      phase_d   = '0;
      dig_d     = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
      phase_d   = phase_q + 2'd1;
      if (phase_q == PH_END)
        dig_d = (dig_q == DG_MAX) ? '0 : dig_q + 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  // Commit reads the old pend_reg, so a same-cycle load stays pending.
  always_comb begin
    pend_reg_d = load ? data_in : pend_reg_q;
    shadow_d   = commit ? pend_reg_q : shadow_q;
    pend_d     = load | (pend_q & ~commit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q  <= '0;
      phase_q    <= '0;
      dig_q      <= '0;
      pend_reg_q <= '0;
      shadow_q   <= '0;
      pend_q     <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      dig_q      <= dig_d;
      pend_reg_q <= pend_reg_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
    end
  end

`ifdef DIGSCAN_LZB_EN
  // hz[i]: digit i and every higher digit are zero.
  logic [NUM_DIGITS:0] hz;
  assign hz[NUM_DIGITS] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_hz
    assign hz[i] = (shadow_q[i] == '0) & hz[i+1];
  end
  assign blank = {hz[NUM_DIGITS-1:1], 1'b0};
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an
    assign an[i] = ~(enable & (dig_q == DG_W'(i)) & (phase_q == PH_ON) & ~blank[i]);
  end

  always_comb begin
    char = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_q == DG_W'(i)) char = shadow_q[i];
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux (4 digits, PRESCALE=2): cycle-tagged expectations
// are queued by the stimulus and consumed by a negedge monitor.
module tb_digit_scan_mux;
  localparam int ND = 4, DW = 4, PS = 2;
  localparam int K_AN = 0, K_CH = 1, K_PD = 2, K_FD = 3;
`ifdef DIGSCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, load = 1'b0;
  logic [ND*DW-1:0] data_in = '0;
  logic [ND-1:0] an;
  logic [DW-1:0] ch;
  logic pending, frame_done;

  digit_scan_mux #(.NUM_DIGITS(ND), .DIG_W(DW), .PRESCALE(PS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .load(load),
    .an(an), .char(ch), .pending(pending), .frame_done(frame_done));

  always #5 clk = ~clk;

  // Cycle index: 0 from reset release, bumps on every rising edge.
  int cnt;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= 0;
    else          cnt <= cnt + 1;

  typedef struct { int cyc; int kind; int val; string name; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  function automatic int actual(int k);
    case (k)
      K_AN:    return int'(an);
      K_CH:    return int'(ch);
      K_PD:    return int'(pending);
      default: return int'(frame_done);
    endcase
  endfunction

  // Monitor: cyc == -1 entries are checked while reset is asserted.
  always @(negedge clk) begin : mon
    exp_t keep[$];
    int cur, a;
    cur = reset_n ? cnt : -1;
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].cyc == cur) begin
        checks++;
        a = actual(sb[i].kind);
        if (a != sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h expected=%0h", sb[i].name, sb[i].cyc, a, sb[i].val);
        end
      end else if (cur >= 0 && sb[i].cyc >= 0 && sb[i].cyc < cur) begin
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d actual=unsampled expected=%0h", sb[i].name, sb[i].cyc, sb[i].val);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic push(input int c, input int k, input int v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic push_rng(input int a, input int b, input int k, input int v, input string n);
    for (int c = a; c <= b; c++) push(c, k, v, n);
  endtask

  task automatic wait_cyc(input int k);
    int g = 0;
    while (cnt < k && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (cnt != k) begin
      checks++; failures++;
      $display("FAIL wait_cyc actual=%0d expected=%0d", cnt, k);
    end
  endtask

  task automatic hold_reset();
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    enable = 1'b1;
    reset_n = 1'b1;
  endtask

  task automatic drain(input string t);
    foreach (sb[i]) begin
      checks++; failures++;
      $display("FAIL %s leftover %s cyc=%0d actual=unchecked expected=%0h", t, sb[i].name, sb[i].cyc, sb[i].val);
    end
    sb.delete();
  endtask

  task automatic end_test(input int last, input string t);
    wait_cyc(last + 1);
    drain(t);
  endtask

  task automatic pulse_load(input int c, input logic [15:0] v);
    wait_cyc(c);
    data_in = v; load = 1'b1;
    wait_cyc(c + 1);
    load = 1'b0;
  endtask

  initial begin
    // Idle frame after reset, no load
    hold_reset();
    push_rng(0, 40, K_PD, 0, "idle_pend");
    push(3, K_AN, 'hF, "idle_an3");
    push_rng(4, 5, K_AN, 'hE, "idle_an_d0");
    push_rng(4, 5, K_CH, 0, "idle_char");
    push(6, K_AN, 'hF, "idle_an6");
    push(12, K_AN, LZB ? 'hF : 'hD, "idle_an_d1");
    push(30, K_FD, 0, "idle_fd30");
    push(31, K_FD, 1, "idle_fd31");
    push(32, K_FD, 0, "idle_fd32");
    release_reset();
    end_test(40, "idle");

    // Single load, commit at frame boundary
    hold_reset();
    push(3, K_PD, 0, "ld_pend3");
    push_rng(4, 31, K_PD, 1, "ld_pend");
    push_rng(4, 31, K_CH, 0, "ld_old_char");
    push_rng(32, 63, K_PD, 0, "ld_pend_clr");
    push_rng(32, 39, K_CH, 0, "ld_char_d0");
    push_rng(40, 47, K_CH, 1, "ld_char_d1");
    push_rng(48, 55, K_CH, 2, "ld_char_d2");
    push_rng(56, 63, K_CH, 3, "ld_char_d3");
    push(44, K_AN, 'hD, "ld_an_d1");
    push_rng(60, 61, K_AN, 'h7, "ld_an_d3");
    push(63, K_FD, 1, "ld_fd63");
    release_reset();
    pulse_load(3, 16'h3210);
    end_test(63, "load");

    // Latest load wins
    hold_reset();
    push(20, K_CH, 0, "lw_char20");
    push_rng(11, 31, K_PD, 1, "lw_pend");
    push(32, K_PD, 0, "lw_pend32");
    push_rng(32, 63, K_CH, 2, "lw_char");
    push_rng(36, 37, K_AN, 'hE, "lw_an_d0");
    release_reset();
    pulse_load(10, 16'h1111);
    pulse_load(20, 16'h2222);
    end_test(63, "latest");

    // Load coinciding with frame_done
    hold_reset();
    push_rng(6, 63, K_PD, 1, "co_pend");
    push(31, K_FD, 1, "co_fd31");
    push(63, K_FD, 1, "co_fd63");
    push_rng(32, 63, K_CH, 5, "co_char5");
    push(64, K_PD, 0, "co_pend64");
    push_rng(64, 71, K_CH, 6, "co_char_d0");
    push_rng(72, 79, K_CH, 7, "co_char_d1");
    push_rng(80, 87, K_CH, 8, "co_char_d2");
    push_rng(88, 95, K_CH, 9, "co_char_d3");
    release_reset();
    pulse_load(5, 16'h5555);
    pulse_load(31, 16'h9876);
    end_test(95, "coincide");

    // Disable while pending, then re-enable
    hold_reset();
    push_rng(6, 12, K_PD, 1, "dis_pend");
    push(12, K_AN, 'hF, "dis_an12");
    push(12, K_CH, 0, "dis_char12");
    push_rng(12, 19, K_FD, 0, "dis_fd");
    push(13, K_PD, 0, "dis_pend13");
    push(13, K_CH, 'hD, "dis_char13");
    push_rng(13, 19, K_AN, 'hF, "dis_an_off");
    push(20, K_CH, 'hD, "dis_char20");
    push(23, K_AN, 'hF, "re_an23");
    push_rng(24, 25, K_AN, 'hE, "re_an_d0");
    push_rng(24, 25, K_CH, 'hD, "re_char_d0");
    push(26, K_AN, 'hF, "re_an26");
    push(51, K_FD, 1, "re_fd51");
    release_reset();
    pulse_load(5, 16'hABCD);
    wait_cyc(12);
    enable = 1'b0;
    wait_cyc(20);
    enable = 1'b1;
    end_test(51, "disable");

    // Leading-zero pattern
    hold_reset();
    push_rng(36, 37, K_AN, 'hE, "lz_an_d0");
    push(36, K_CH, 0, "lz_char_d0");
    push_rng(44, 45, K_AN, 'hD, "lz_an_d1");
    push(44, K_CH, 5, "lz_char_d1");
    push_rng(52, 53, K_AN, LZB ? 'hF : 'hB, "lz_an_d2");
    push(52, K_CH, 0, "lz_char_d2");
    push_rng(60, 61, K_AN, LZB ? 'hF : 'h7, "lz_an_d3");
    push(60, K_CH, 0, "lz_char_d3");
    release_reset();
    pulse_load(3, 16'h0050);
    end_test(63, "lzb");

    // Asynchronous reset mid-frame
    hold_reset();
    push(44, K_AN, 'hD, "rst_pre_an");
    push(44, K_CH, 3, "rst_pre_char");
    push(44, K_PD, 1, "rst_pre_pend");
    release_reset();
    pulse_load(3, 16'h1234);
    pulse_load(40, 16'h4321);
    wait_cyc(45);
    push(-1, K_AN, 'hF, "rst_an");
    push(-1, K_CH, 0, "rst_char");
    push(-1, K_PD, 0, "rst_pend");
    push(-1, K_FD, 0, "rst_fd");
    reset_n = 1'b0;
    @(negedge clk); #1;
    drain("reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
